// File: rtl/regfile_sequencer.sv
// Four-state instruction sequencer driving an external register file:
// fetch operands, execute (single-cycle ALU or 16-cycle shift-add multiply), write back.
module regfile_sequencer #(
  parameter int MUL_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  rf_addr_read1,
  output logic [2:0]  rf_addr_read2,
  input  logic [15:0] rf_data_out1,
  input  logic [15:0] rf_data_out2,
  output logic [2:0]  rf_addr_write,
  output logic [15:0] rf_data_in,
  output logic        rf_we,
  output logic        done,
  output logic        illegal,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] instr_reg;
  logic [15:0] opa_reg, opb_reg;
  logic [15:0] result_reg;
  logic [15:0] acc_reg;
  logic [3:0]  cnt_reg;
  logic        zero_reg;

  logic [3:0]  op;
  logic        is_mul, is_legal, is_write;
  logic [15:0] alu_result;
  logic [15:0] mul_partial, acc_sum;

  assign op = instr_reg[15:12];

  // Opcode 8 is only a legal instruction when the multiplier is built in
  always_comb begin
    is_mul   = (op == 4'd8) && (MUL_EN != 0);
    is_legal = (op <= 4'd9) && ((op != 4'd8) || (MUL_EN != 0));
    is_write = is_legal && (op != 4'd0);
  end

  always_comb begin
    alu_result = result_reg;
    case (op)
      4'd1:    alu_result = opa_reg + opb_reg;
      4'd2:    alu_result = opa_reg - opb_reg;
      4'd3:    alu_result = opa_reg & opb_reg;
      4'd4:    alu_result = opa_reg | opb_reg;
      4'd5:    alu_result = opa_reg ^ opb_reg;
      4'd6:    alu_result = opa_reg << opb_reg[3:0];
      4'd7:    alu_result = opa_reg >> opb_reg[3:0];
      4'd9:    alu_result = opa_reg + {10'd0, instr_reg[5:0]};
      default: alu_result = result_reg;
    endcase
  end

  // One multiplier bit per EXEC cycle; the accumulator stays separate so
  // rf_data_in keeps showing the previous result while the multiply runs
  always_comb begin
    mul_partial = opb_reg[cnt_reg] ? (opa_reg << cnt_reg) : 16'd0;
    acc_sum     = acc_reg + mul_partial;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (instr_valid) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    if (!is_mul || (cnt_reg == 4'd15)) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      instr_reg  <= 16'd0;
      opa_reg    <= 16'd0;
      opb_reg    <= 16'd0;
      result_reg <= 16'd0;
      acc_reg    <= 16'd0;
      cnt_reg    <= 4'd0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (instr_valid) instr_reg <= instr;
        READ: begin
          opa_reg <= rf_data_out1;
          opb_reg <= rf_data_out2;
          acc_reg <= 16'd0;
          cnt_reg <= 4'd0;
        end
        EXEC: begin
          if (is_mul) begin
            acc_reg <= acc_sum;
            cnt_reg <= cnt_reg + 4'd1;
            if (cnt_reg == 4'd15) begin
              result_reg <= acc_sum;
              zero_reg   <= (acc_sum == 16'd0);
            end
          end else if (is_write) begin
            // zero is settled by the time WRITE is visible
            result_reg <= alu_result;
            zero_reg   <= (alu_result == 16'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_ready   = (state_reg == IDLE) && !rst;
  assign done          = (state_reg == WRITE) && !rst;
  assign rf_we         = (state_reg == WRITE) && is_write && !rst;
  assign illegal       = (state_reg == WRITE) && !is_legal && !rst;
  assign rf_addr_read1 = instr_reg[8:6];
  assign rf_addr_read2 = instr_reg[5:3];
  assign rf_addr_write = instr_reg[11:9];
  assign rf_data_in    = result_reg;
  assign zero          = zero_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: a behavioural register file with falling-edge
// writes, hand-computed results, latency and reset-abort checks.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  rf_addr_read1, rf_addr_read2, rf_addr_write;
  logic [15:0] rf_data_out1, rf_data_out2, rf_data_in;
  logic        rf_we, done, illegal, zero;

  // second instance built without the multiplier
  logic [15:0] instr_nm;
  logic        instr_valid_nm, instr_ready_nm;
  logic [2:0]  ra1_nm, ra2_nm, wa_nm;
  logic [15:0] wd_nm;
  logic        we_nm, done_nm, illegal_nm, zero_nm;
  logic [15:0] rd_const_nm = 16'd3;

  logic [15:0] rf [8];
  logic        poke_en;
  logic [2:0]  poke_addr;
  logic [15:0] poke_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(.MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_addr_read1(rf_addr_read1),
    .rf_addr_read2(rf_addr_read2), .rf_data_out1(rf_data_out1),
    .rf_data_out2(rf_data_out2), .rf_addr_write(rf_addr_write),
    .rf_data_in(rf_data_in), .rf_we(rf_we), .done(done),
    .illegal(illegal), .zero(zero)
  );

  regfile_sequencer #(.MUL_EN(0)) dut_nomul (
    .clk(clk), .rst(rst), .instr(instr_nm), .instr_valid(instr_valid_nm),
    .instr_ready(instr_ready_nm), .rf_addr_read1(ra1_nm),
    .rf_addr_read2(ra2_nm), .rf_data_out1(rd_const_nm),
    .rf_data_out2(rd_const_nm), .rf_addr_write(wa_nm),
    .rf_data_in(wd_nm), .rf_we(we_nm), .done(done_nm),
    .illegal(illegal_nm), .zero(zero_nm)
  );

  // Register file model: r0 hardwired to zero, writes land on the falling edge
  assign rf_data_out1 = rf[rf_addr_read1];
  assign rf_data_out2 = rf[rf_addr_read2];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
      rf[1] <= 16'd5;
      rf[2] <= 16'd1;
    end else if (poke_en) begin
      rf[poke_addr] <= poke_data;
    end else if (rf_we && (rf_addr_write != 3'd0)) begin
      rf[rf_addr_write] <= rf_data_in;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk);
    #1 poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [15:0] ins);
    @(negedge clk);
    check_eq({tag, "_ready"}, instr_ready, 1'b1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 16'hC000;  // junk that must not be latched while busy
  endtask

  // Wait for done (bounded) and check the retiring cycle against expectations
  task automatic finish_instr(input string tag, input int exp_cyc, input logic exp_we,
                              input logic [2:0] exp_addr, input logic [15:0] exp_data,
                              input logic exp_ill, input logic exp_zero);
    int cyc = 0;
    logic seen = 1'b0, stray = 1'b0;
    logic we_s = 1'b0, ill_s = 1'b0, z_s = 1'b0;
    logic [2:0] a_s = 3'd0;
    logic [15:0] d_s = 16'd0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
        we_s = rf_we; ill_s = illegal; z_s = zero; a_s = rf_addr_write; d_s = rf_data_in;
      end else if (rf_we || illegal) begin
        stray = 1'b1;
      end
    end
    $display("txn %s cyc=%0d we=%0b addr=%0d data=%04h illegal=%0b zero=%0b",
             tag, cyc, we_s, a_s, d_s, ill_s, z_s);
    check_eq({tag, "_cycle"}, cyc, exp_cyc);
    check_eq({tag, "_stray"}, stray, 1'b0);
    check_eq({tag, "_we"}, we_s, exp_we);
    check_eq({tag, "_illegal"}, ill_s, exp_ill);
    check_eq({tag, "_zero"}, z_s, exp_zero);
    check_eq({tag, "_data"}, d_s, exp_data);
    if (exp_we) check_eq({tag, "_addr"}, a_s, exp_addr);
  endtask

  initial begin
    int cyc;
    logic bad;
    rst = 1'b1; instr = 16'd0; instr_valid = 1'b0;
    instr_nm = 16'd0; instr_valid_nm = 1'b0;
    poke_en = 1'b0; poke_addr = 3'd0; poke_data = 16'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", instr_ready, 1'b0);
    check_eq("rst_we", rf_we, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_illegal", illegal, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", instr_ready, 1'b1);
    check_eq("post_rst_zero", zero, 1'b0);
    check_eq("post_rst_data", rf_data_in, 16'd0);
    check_eq("post_rst_waddr", rf_addr_write, 3'd0);

    // op, rd, rs, rt
    issue("add", enc(4'd1, 3'd3, 3'd1, 3'd2));  finish_instr("add", 3, 1, 3'd3, 16'd6, 0, 0);
    issue("sub", enc(4'd2, 3'd4, 3'd2, 3'd2));  finish_instr("sub", 3, 1, 3'd4, 16'd0, 0, 1);
    issue("sll", enc(4'd6, 3'd5, 3'd1, 3'd2));  finish_instr("sll", 3, 1, 3'd5, 16'd10, 0, 0);
    issue("and", enc(4'd3, 3'd7, 3'd1, 3'd3));  finish_instr("and", 3, 1, 3'd7, 16'd4, 0, 0);
    issue("or",  enc(4'd4, 3'd7, 3'd1, 3'd3));  finish_instr("or",  3, 1, 3'd7, 16'd7, 0, 0);
    issue("xor", enc(4'd5, 3'd7, 3'd1, 3'd3));  finish_instr("xor", 3, 1, 3'd7, 16'd3, 0, 0);
    issue("srl", enc(4'd7, 3'd7, 3'd3, 3'd2));  finish_instr("srl", 3, 1, 3'd7, 16'd3, 0, 0);
    issue("nop", enc(4'd0, 3'd0, 3'd0, 3'd0));  finish_instr("nop", 3, 0, 3'd0, 16'd3, 0, 0);
    issue("ill12", enc(4'd12, 3'd2, 3'd1, 3'd1)); finish_instr("ill12", 3, 0, 3'd2, 16'd3, 1, 0);
    issue("addi_r0", {4'd9, 3'd0, 3'd1, 6'd63}); finish_instr("addi_r0", 3, 1, 3'd0, 16'd68, 0, 0);
    issue("read_r0", enc(4'd1, 3'd7, 3'd0, 3'd0)); finish_instr("read_r0", 3, 1, 3'd7, 16'd0, 0, 1);

    poke(3'd1, 16'h0100);
    issue("mul_wrap", enc(4'd8, 3'd6, 3'd1, 3'd1)); finish_instr("mul_wrap", 18, 1, 3'd6, 16'h0000, 0, 1);
    poke(3'd1, 16'd5);
    issue("mul_5x5", enc(4'd8, 3'd6, 3'd1, 3'd1)); finish_instr("mul_5x5", 18, 1, 3'd6, 16'd25, 0, 0);
    @(negedge clk);
    check_eq("rf_r6", rf[6], 16'd25);

    // instr_valid held high: second accept only after WRITE
    @(negedge clk);
    instr = enc(4'd1, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("b2b_ready_c%0d", c), instr_ready, (c == 4));
      if (c == 3) check_eq("b2b_done_c3", done, 1'b1);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    finish_instr("b2b_second", 3, 1, 3'd3, 16'd6, 0, 0);

    // rst pulsed in the 7th EXEC cycle of a multiply
    issue("mul_abort", enc(4'd8, 3'd6, 3'd1, 3'd1));
    for (int c = 1; c <= 8; c++) @(negedge clk);
    rst = 1'b1;
    #1 check_eq("abort_we_in_rst", rf_we, 1'b0);
    check_eq("abort_ready_in_rst", instr_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("abort_ready_after", instr_ready, 1'b1);
    check_eq("abort_zero", zero, 1'b0);
    bad = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (rf_we || done || !instr_ready) bad = 1'b1;
    end
    $display("txn mul_abort idle_violation=%0b", bad);
    check_eq("abort_quiet", bad, 1'b0);

    // MUL_EN = 0: opcode 8 retires as illegal
    @(negedge clk);
    check_eq("nomul_ready", instr_ready_nm, 1'b1);
    instr_nm = enc(4'd8, 3'd6, 3'd1, 3'd1);
    instr_valid_nm = 1'b1;
    @(posedge clk);
    #1 instr_valid_nm = 1'b0;
    cyc = 0;
    bad = 1'b0;
    while (!done_nm && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (we_nm) bad = 1'b1;
    end
    $display("txn nomul_op8 cyc=%0d illegal=%0b we_seen=%0b", cyc, illegal_nm, bad);
    check_eq("nomul_cycle", cyc, 3);
    check_eq("nomul_illegal", illegal_nm, 1'b1);
    check_eq("nomul_we", bad, 1'b0);
    check_eq("nomul_data", wd_nm, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
